// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts the ones in a fixed window of a stochastic bit stream.
// Latency: start at edge t -> first counted bit in cycle t+1+SKIP, o_valid during cycle t+1+SKIP+WINDOW.
// Backpressure: none; the stream is consumed one bit per clock, start while busy is ignored, stop aborts.
//
// Ports:
//   i_clk_stb    clock, rising edge
//   i_rst_stb    asynchronous active-high reset
//   i_sn_bit     stochastic input bit, one per cycle
//   i_start_stb  single-cycle pulse that begins a conversion (accepted in IDLE and DONE)
//   i_stop_stb   abort of an in-progress conversion (SKIP/CNT only)
//   o_bn_value   count of ones from the last completed window
//   o_valid      one-cycle pulse when o_bn_value has just updated
//   o_busy       high while skipping or counting
//   o_bn_signed  (only with SN_TO_BN_BIPOLAR_EN) bipolar decode 2*count - WINDOW, two's complement
//
// Optional feature macro: SN_TO_BN_BIPOLAR_EN

module sn_to_bn #(
  parameter int WINDOW = 16,
  parameter int SKIP   = 0,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             i_clk_stb,
  input  logic             i_rst_stb,
  input  logic             i_sn_bit,
  input  logic             i_start_stb,
  input  logic             i_stop_stb,
  output logic [CNT_W-1:0] o_bn_value,
  output logic             o_valid,
  output logic             o_busy
`ifdef SN_TO_BN_BIPOLAR_EN
  ,
  output logic [CNT_W:0]   o_bn_signed
`endif
);

  // pos_cnt must hold both WINDOW-1 and SKIP-1 (SKIP is at most 15).
  localparam int POS_W = ($clog2(WINDOW) < 4) ? 4 : $clog2(WINDOW);

  localparam logic [POS_W-1:0] WIN_LD  = POS_W'(WINDOW - 1);
  localparam logic [POS_W-1:0] SKIP_LD = (SKIP > 0) ? POS_W'(SKIP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_CNT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [POS_W-1:0] pos_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] next_cnt;

  // Count including the bit present this cycle, so the final sample lands in the result.
  assign next_cnt = ones_cnt + {{(CNT_W-1){1'b0}}, i_sn_bit};

  always_comb begin
    o_busy = (state == ST_SKIP) || (state == ST_CNT);
  end

  always_ff @(posedge i_clk_stb or posedge i_rst_stb) begin
    if (i_rst_stb) begin
      state       <= ST_IDLE;
      pos_cnt     <= '0;
      ones_cnt    <= '0;
      o_bn_value  <= '0;
      o_valid     <= 1'b0;
`ifdef SN_TO_BN_BIPOLAR_EN
      o_bn_signed <= (CNT_W+1)'(-WINDOW);
`endif
    end else begin
      o_valid <= 1'b0;
      case (state)
        // DONE shares the IDLE start path so conversions can run back to back.
        ST_IDLE, ST_DONE: begin
          if (i_start_stb) begin
            ones_cnt <= '0;
            if (SKIP > 0) begin
              state   <= ST_SKIP;
              pos_cnt <= SKIP_LD;
            end else begin
              state   <= ST_CNT;
              pos_cnt <= WIN_LD;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SKIP: begin
          if (i_stop_stb) begin
            state <= ST_IDLE;
          end else if (pos_cnt == '0) begin
            state   <= ST_CNT;
            pos_cnt <= WIN_LD;
          end else begin
            pos_cnt <= pos_cnt - 1'b1;
          end
        end

        ST_CNT: begin
          if (i_stop_stb) begin
            state <= ST_IDLE;
          end else begin
            ones_cnt <= next_cnt;
            if (pos_cnt == '0) begin
              state      <= ST_DONE;
              o_bn_value <= next_cnt;
              o_valid    <= 1'b1;
`ifdef SN_TO_BN_BIPOLAR_EN
              o_bn_signed <= {next_cnt, 1'b0} - (CNT_W+1)'(WINDOW);
`endif
            end else begin
              pos_cnt <= pos_cnt - 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sn_to_bn.md
Name: sn_to_bn

Overview:
- Stochastic-to-binary converter; sits directly downstream of the 4-bit stochastic number generator and its bitwise stochastic compute stage.
- Consumes one stochastic bit per clock over a fixed window and counts the ones.
- Presents the count as a binary value with a one-cycle valid pulse, for the accumulate/activation stage that follows.

Parameters:
- WINDOW, 16: stream length in bits counted per conversion; legal range 2..256.
- SKIP, 0: number of leading stream bits after start that are discarded, to absorb upstream pipeline latency; legal range 0..15.
- CNT_W, $clog2(WINDOW+1): width of the count output; 5 at the default.

Ports:
- i_clk_stb  input  1  clock; all state changes on the rising edge.
- i_rst_stb  input  1  reset, asynchronous, active-high.
- i_sn_bit  input  1  stochastic bit stream, one bit per cycle.
- i_start_stb  input  1  single-cycle pulse; begins a conversion.
- i_stop_stb  input  1  abort; cancels an in-progress conversion.
- o_bn_value  output  CNT_W  number of ones seen in the last completed window.
- o_valid  output  1  one-cycle pulse: o_bn_value just updated.
- o_busy  output  1  high while in SKIP or CNT.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-conversion): state=IDLE, o_bn_value=0, o_valid=0, o_busy=0, internal counters=0.
- States: IDLE, SKIP, CNT, DONE. Two counters:
  - pos_cnt: bits remaining in the current phase.
  - ones_cnt: CNT_W bits wide; cannot overflow, since it is at most WINDOW.
- IDLE:
  - i_start_stb=1 -> SKIP with pos_cnt=SKIP-1 if SKIP>0; otherwise -> CNT with pos_cnt=WINDOW-1.
  - On start, ones_cnt is cleared to 0.
  - i_stop_stb is ignored in IDLE. Start and stop together in IDLE: start wins.
- SKIP:
  - i_sn_bit is ignored; pos_cnt decrements each cycle.
  - At pos_cnt=0 -> CNT with pos_cnt=WINDOW-1.
- CNT:
  - ones_cnt += i_sn_bit on each cycle; pos_cnt decrements.
  - The cycle with pos_cnt=0 samples the final bit -> DONE.
  - Exactly WINDOW bits are sampled.
- DONE (one cycle):
  - o_bn_value <= final ones_cnt, including the last sampled bit; o_valid=1 for this cycle only.
  - i_start_stb=1 in DONE is accepted with IDLE start semantics (back-to-back conversions, no gap cycle); otherwise -> IDLE.
- Latency: start sampled at edge t. The first counted bit is the one present during cycle t+1+SKIP. o_valid is high during cycle t+1+SKIP+WINDOW.
- i_stop_stb=1 in SKIP or CNT -> IDLE next cycle:
  - no o_valid pulse; o_bn_value keeps its previous value; ones_cnt is discarded.
  - If stop and start are both high in SKIP/CNT, stop wins and start is ignored.
- i_stop_stb in DONE is ignored; the result still posts.
- i_start_stb while busy (SKIP/CNT) is ignored; the conversion continues unchanged.
- o_busy is a combinational decode of the state register: 1 in SKIP and CNT, 0 in IDLE and DONE.
- o_bn_value holds between conversions and changes only on entering DONE, or on reset.

Optional Feature:
- Macro SN_TO_BN_BIPOLAR_EN.
- Defined:
  - adds output port o_bn_signed, CNT_W+1 bits, two's complement, = 2*ones_cnt - WINDOW (bipolar decode).
  - It updates in the same cycle as o_bn_value and is reset to -WINDOW (all-zeros count).
  - For WINDOW=16: count 0 -> -16, count 8 -> 0, count 16 -> +16.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-CNT:
  - Stimulus: start, feed 8 ones, assert i_rst_stb.
  - Response: o_busy=0, o_valid=0, o_bn_value=0 immediately. Next start with all-zero stream -> o_bn_value=0, o_valid pulse exactly 17 cycles after start (SKIP=0, WINDOW=16).
- Density sweep (WINDOW=16, SKIP=0):
  - Stimulus: streams with 0, 1, 5, 15, 16 ones.
  - Response: o_bn_value = 0, 1, 5, 15, 16; exactly one o_valid pulse each; o_busy high for exactly 16 cycles.
- SKIP=2:
  - Stimulus: stream starting 1,1 followed by 16 zeros.
  - Response: o_bn_value=0, valid 19 cycles after start. Stream 0,0 followed by 16 ones -> 16.
- Abort:
  - Stimulus: conversion producing 9 completes; next conversion gets i_stop_stb after 6 bits.
  - Response: no o_valid, o_bn_value stays 9, o_busy drops the next cycle. A start asserted in the same cycle as the stop is ignored.
- Back-to-back:
  - Stimulus: i_start_stb asserted in the DONE cycle; streams of 3 ones then 12 ones.
  - Response: valids 17 cycles apart with values 3 then 12. A start pulsed during CNT is ignored (single valid).
- SN_TO_BN_BIPOLAR_EN build:
  - Stimulus: counts 0, 8, 16.
  - Response: o_bn_signed = -16, 0, +16; after reset = -16.
